// File: rtl/commit_trace_checker.sv
// Lock-step commit trace checker: two per-copy FIFOs of {mem_valid, addr} entries are
// popped in pairs and compared. Optional skew check is enabled by TRACE_CHECK_SKEW_EN.

module trace_fifo #(
  parameter int EW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [EW-1:0]            wdata,
  input  logic                     pop,
  output logic [EW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   occ,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW:0]   wp, rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[PW-1:0]] <= wdata;
  end

  // extra wrap bit keeps full (occ==DEPTH) distinct from empty
  assign occ   = wp - rp;
  assign full  = (occ == (PW+1)'(DEPTH));
  assign empty = (wp == rp);
  assign rdata = mem[rp[PW-1:0]];
endmodule

module commit_trace_checker #(
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_SKEW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_1,
  input  logic                   mem_valid_1,
  input  logic [ADDR_W-1:0]      mem_addr_1,
  input  logic                   commit_2,
  input  logic                   mem_valid_2,
  input  logic [ADDR_W-1:0]      mem_addr_2,
  output logic                   mismatch,
  output logic [1:0]             cause,
  output logic [ADDR_W-1:0]      fail_addr_1,
  output logic [ADDR_W-1:0]      fail_addr_2,
  output logic [15:0]            cmp_count,
  output logic [$clog2(DEPTH):0] occ_1,
  output logic [$clog2(DEPTH):0] occ_2
);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + 1;

  typedef enum logic {CHECK, FAIL} state_t;
  state_t state, state_nxt;

  logic [1:0]              req, push_en, full, empty, ovf;
  logic [1:0][EW-1:0]      wdata, rdata;
  logic [1:0][OW-1:0]      occ;
  logic                    pop, chk_on;
  logic                    cmp_vld;
  logic [EW-1:0]           cmp_1, cmp_2;
  logic                    data_bad, data_ok, skew_bad;
  logic [1:0]              cause_nxt;
  logic [ADDR_W-1:0]       fa1_nxt, fa2_nxt;

  assign chk_on   = (state == CHECK);
  assign req      = {commit_2 | mem_valid_2, commit_1 | mem_valid_1};
  assign wdata[0] = {mem_valid_1, mem_valid_1 ? mem_addr_1 : {ADDR_W{1'b0}}};
  assign wdata[1] = {mem_valid_2, mem_valid_2 ? mem_addr_2 : {ADDR_W{1'b0}}};
  assign pop      = chk_on && !empty[0] && !empty[1];

  for (genvar n = 0; n < 2; n++) begin : g_lane
    // a full FIFO still accepts a push when the same cycle pops it
    assign ovf[n]     = chk_on && req[n] && full[n] && !pop;
    assign push_en[n] = chk_on && req[n] && !ovf[n];

    trace_fifo #(.EW(EW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_en[n]),
      .wdata (wdata[n]),
      .pop   (pop),
      .rdata (rdata[n]),
      .occ   (occ[n]),
      .full  (full[n]),
      .empty (empty[n])
    );
  end

  assign occ_1 = occ[0];
  assign occ_2 = occ[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_vld <= 1'b0;
      cmp_1   <= '0;
      cmp_2   <= '0;
    end else begin
      cmp_vld <= pop;
      if (pop) begin
        cmp_1 <= rdata[0];
        cmp_2 <= rdata[1];
      end
    end
  end

  // invalid entries carry a zero address, so whole-entry equality is the match rule
  assign data_bad = cmp_vld && (cmp_1 != cmp_2);
  assign data_ok  = cmp_vld && (cmp_1 == cmp_2);

`ifdef TRACE_CHECK_SKEW_EN
  logic [OW-1:0] nxt_1, nxt_2, skew_d;
  always_comb begin
    nxt_1  = occ[0] + OW'(push_en[0]) - OW'(pop);
    nxt_2  = occ[1] + OW'(push_en[1]) - OW'(pop);
    skew_d = (nxt_1 > nxt_2) ? (nxt_1 - nxt_2) : (nxt_2 - nxt_1);
  end
  assign skew_bad = chk_on && (int'(skew_d) > MAX_SKEW);
`else
  assign skew_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    fa1_nxt   = fail_addr_1;
    fa2_nxt   = fail_addr_2;
    if (state == CHECK) begin
      if (|ovf) begin
        state_nxt = FAIL;
        cause_nxt = 2'd3;
      end else if (skew_bad) begin
        state_nxt = FAIL;
        cause_nxt = 2'd2;
      end else if (data_bad) begin
        state_nxt = FAIL;
        cause_nxt = 2'd1;
        fa1_nxt   = cmp_1[ADDR_W-1:0];
        fa2_nxt   = cmp_2[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CHECK;
      mismatch    <= 1'b0;
      cause       <= 2'd0;
      fail_addr_1 <= '0;
      fail_addr_2 <= '0;
      cmp_count   <= '0;
    end else begin
      state       <= state_nxt;
      mismatch    <= (state_nxt == FAIL);
      cause       <= cause_nxt;
      fail_addr_1 <= fa1_nxt;
      fail_addr_2 <= fa2_nxt;
      if (chk_on && data_ok && cmp_count != 16'hFFFF)
        cmp_count <= cmp_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker (DEPTH=4, MAX_SKEW=2); skew expectations
// follow TRACE_CHECK_SKEW_EN.

module tb_commit_trace_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic        commit_1, mem_valid_1, commit_2, mem_valid_2;
  logic [31:0] mem_addr_1, mem_addr_2;
  logic        mismatch;
  logic [1:0]  cause;
  logic [31:0] fail_addr_1, fail_addr_2;
  logic [15:0] cmp_count;
  logic [2:0]  occ_1, occ_2;

  int n_chk  = 0;
  int n_fail = 0;

  commit_trace_checker #(.ADDR_W(32), .DEPTH(4), .MAX_SKEW(2)) dut (
    .clk(clk), .rst(rst),
    .commit_1(commit_1), .mem_valid_1(mem_valid_1), .mem_addr_1(mem_addr_1),
    .commit_2(commit_2), .mem_valid_2(mem_valid_2), .mem_addr_2(mem_addr_2),
    .mismatch(mismatch), .cause(cause),
    .fail_addr_1(fail_addr_1), .fail_addr_2(fail_addr_2),
    .cmp_count(cmp_count), .occ_1(occ_1), .occ_2(occ_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic c1, input logic v1, input logic [31:0] a1,
                     input logic c2, input logic v2, input logic [31:0] a2);
    commit_1 = c1; mem_valid_1 = v1; mem_addr_1 = a1;
    commit_2 = c2; mem_valid_2 = v2; mem_addr_2 = a2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // commits are held high during reset to show they are ignored
  task automatic do_reset();
    rst = 1'b1;
    commit_1 = 1'b1; mem_valid_1 = 1'b1; mem_addr_1 = 32'h55;
    commit_2 = 1'b1; mem_valid_2 = 1'b1; mem_addr_2 = 32'hAA;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    commit_1 = 0; mem_valid_1 = 0; mem_addr_1 = 0;
    commit_2 = 0; mem_valid_2 = 0; mem_addr_2 = 0;
    do_reset();
    chk("rst_mismatch", mismatch, 0);
    chk("rst_cause", cause, 0);
    chk("rst_count", cmp_count, 0);
    chk("rst_occ1", occ_1, 0);
    chk("rst_occ2", occ_2, 0);
    chk("rst_fa1", fail_addr_1, 0);

    // identical streams; odd slots commit without memory access, addresses differ but are masked
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) cyc(1'b1, 1'b1, 32'h1000 + 4*i, 1'b1, 1'b1, 32'h1000 + 4*i);
      else            cyc(1'b1, 1'b0, 32'(i),         1'b1, 1'b0, 32'hDEAD);
    end
    idle(3);
    chk("ident_count", cmp_count, 10);
    chk("ident_mismatch", mismatch, 0);
    chk("ident_occ1", occ_1, 0);
    chk("ident_occ2", occ_2, 0);

    // non-committing address leak must be traced and compared
    cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 32'h200);
    idle(3);
    chk("leak_count", cmp_count, 11);

    // delayed copy 2 by one cycle
    do_reset();
    idle(3);
    cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    chk("delay_occ1", occ_1, 1);
    chk("delay_occ2", occ_2, 0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100);
    idle(3);
    chk("delay_count", cmp_count, 1);
    chk("delay_mismatch", mismatch, 0);
    chk("delay_occ1_end", occ_1, 0);

    // address difference on third commit
    do_reset();
    cyc(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h40);
    cyc(1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 32'h44);
    cyc(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 32'h104);
    idle(3);
    chk("addr_mismatch", mismatch, 1);
    chk("addr_cause", cause, 1);
    chk("addr_fa1", fail_addr_1, 32'h100);
    chk("addr_fa2", fail_addr_2, 32'h104);
    chk("addr_count", cmp_count, 2);
    // FAIL ignores further traffic and freezes the failure record
    cyc(1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h9);
    cyc(1'b1, 1'b1, 32'h8, 1'b1, 1'b1, 32'h8);
    idle(3);
    chk("fail_occ1", occ_1, 0);
    chk("fail_count", cmp_count, 2);
    chk("fail_fa1", fail_addr_1, 32'h100);

    // reset out of FAIL, then a normal matching stream
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rfail_mismatch", mismatch, 0);
    chk("rfail_cause", cause, 0);
    chk("rfail_count", cmp_count, 0);
    chk("rfail_fa2", fail_addr_2, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h300 + i, 1'b1, 1'b1, 32'h300 + i);
    idle(3);
    chk("rfail_stream_count", cmp_count, 3);
    chk("rfail_stream_mismatch", mismatch, 0);

    // skew: copy 1 runs three entries ahead
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h500 + i, 1'b0, 1'b0, 32'h0);
    idle(1);
`ifdef TRACE_CHECK_SKEW_EN
    chk("skew_mismatch", mismatch, 1);
    chk("skew_cause", cause, 2);
    chk("skew_fa1", fail_addr_1, 0);
`else
    chk("skew_mismatch", mismatch, 0);
    chk("skew_occ1", occ_1, 3);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h500 + i);
    idle(3);
    chk("skew_catchup_count", cmp_count, 3);
`endif

    // overflow: five pushes into a 4-deep FIFO with copy 2 idle
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 32'h600 + i, 1'b0, 1'b0, 32'h0);
`ifdef TRACE_CHECK_SKEW_EN
    chk("ovf_skew_cause", cause, 2);
    chk("ovf_skew_occ1", occ_1, 3);
`else
    chk("ovf_pre_mismatch", mismatch, 0);
    chk("ovf_pre_occ1", occ_1, 4);
    cyc(1'b1, 1'b1, 32'h604, 1'b0, 1'b0, 32'h0);
    chk("ovf_mismatch", mismatch, 1);
    chk("ovf_cause", cause, 3);
    chk("ovf_occ1", occ_1, 4);
    chk("ovf_fa1", fail_addr_1, 0);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600);
    idle(2);
    chk("ovf_frozen_occ2", occ_2, 0);
    chk("ovf_frozen_cause", cause, 3);

    // push and pop on a full FIFO in the same cycle is not an overflow
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 32'h700 + i, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 32'h703, 1'b1, 1'b1, 32'h700);
    chk("full_occ1", occ_1, 4);
    cyc(1'b1, 1'b1, 32'h704, 1'b1, 1'b1, 32'h701);
    chk("full_pp_occ1", occ_1, 4);
    chk("full_pp_mismatch", mismatch, 0);
    for (int i = 2; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h700 + i);
    idle(4);
    chk("full_count", cmp_count, 5);
    chk("full_occ1_end", occ_1, 0);
    chk("full_mismatch_end", mismatch, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
